// File: rtl/mem_responder.sv
// Memory-side responder for the controller's rd/wr strobe bus: edge-detects each strobe,
// inserts WAIT wait states, then reads or writes an internal word RAM and reports errors.
module mem_responder #(
   parameter int DW    = 8,
   parameter int AW    = 13,
   parameter int DEPTH = 256,
   parameter int WAIT  = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rd,
   input  logic          wr,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata,
   output logic          rdata_vld,
   output logic          ack,
   output logic          busy,
   output logic          err
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, WAITST, RESP, HOLD} state_t;

   state_t          state, state_nx;
   logic            rd_q, wr_q;
   logic            rd_rise, wr_rise;
   logic [3:0]      cnt, cnt_nx;
   logic            op_wr, op_wr_nx;
   logic [AW-1:0]   addr_c, addr_c_nx;
   logic [DW-1:0]   wdata_c, wdata_c_nx;
   logic [DW-1:0]   rdata_nx;
   logic            vld_nx, ack_nx, err_nx;
   logic            mem_we;
   logic            in_range;
   logic            strobe;
   logic [IW-1:0]   idx;
   logic [DW-1:0]   mem [DEPTH];

   assign rd_rise  = rd & ~rd_q;
   assign wr_rise  = wr & ~wr_q;
   // Full-width unsigned compare; the extra bit keeps DEPTH == 2**AW representable.
   assign in_range = ({1'b0, addr_c} < (AW+1)'(DEPTH));
   assign idx      = addr_c[IW-1:0];
   assign strobe   = op_wr ? wr : rd;
   assign busy     = (state != IDLE);

   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      op_wr_nx   = op_wr;
      addr_c_nx  = addr_c;
      wdata_c_nx = wdata_c;
      rdata_nx   = rdata;
      vld_nx     = rdata_vld;
      ack_nx     = 1'b0;
      err_nx     = 1'b0;
      mem_we     = 1'b0;
      case (state)
         IDLE: begin
            if (rd_rise && wr_rise) begin
               err_nx = 1'b1;
            end else if (rd_rise || wr_rise) begin
               op_wr_nx   = wr_rise;
               addr_c_nx  = addr;
               wdata_c_nx = wdata;
               if (WAIT > 0) begin
                  state_nx = WAITST;
                  cnt_nx   = 4'(WAIT - 1);
               end else begin
                  state_nx = RESP;
               end
            end
         end
         WAITST: begin
            err_nx = rd_rise | wr_rise;
            if (cnt == 4'd0) state_nx = RESP;
            else             cnt_nx   = cnt - 4'd1;
         end
         RESP: begin
            err_nx   = rd_rise | wr_rise;
            state_nx = HOLD;
            if (!in_range) begin
               err_nx   = 1'b1;
               rdata_nx = '0;
               vld_nx   = 1'b0;
            end else if (op_wr) begin
               mem_we = 1'b1;
               ack_nx = 1'b1;
            end else begin
               rdata_nx = mem[idx];
               // A read whose strobe already fell still updates rdata but is not flagged valid.
               vld_nx   = strobe;
            end
         end
         HOLD: begin
            err_nx = rd_rise | wr_rise;
            if (!strobe) begin
               state_nx = IDLE;
               vld_nx   = 1'b0;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         rd_q      <= 1'b0;
         wr_q      <= 1'b0;
         cnt       <= '0;
         op_wr     <= 1'b0;
         addr_c    <= '0;
         wdata_c   <= '0;
         rdata     <= '0;
         rdata_vld <= 1'b0;
         ack       <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_nx;
         rd_q      <= rd;
         wr_q      <= wr;
         cnt       <= cnt_nx;
         op_wr     <= op_wr_nx;
         addr_c    <= addr_c_nx;
         wdata_c   <= wdata_c_nx;
         rdata     <= rdata_nx;
         rdata_vld <= vld_nx;
         ack       <= ack_nx;
         err       <= err_nx;
      end
   end

   // RAM contents survive reset; writes only happen from RESP, which reset leaves immediately.
   always_ff @(posedge clk) begin
      if (mem_we) mem[idx] <= wdata_c;
   end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder with a cycle-level expectation model derived from the
// strobe/latency rules and a reference RAM array.
module tb_mem_responder;

   localparam int DW     = 8;
   localparam int AW     = 13;
   localparam int DEPTH  = 256;
   localparam int WAIT_T = 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          rd, wr;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic [DW-1:0] rdata;
   logic          rdata_vld, ack, busy, err;

   logic [DW-1:0] ref_mem [DEPTH];
   logic [DW-1:0] exp_rdata;
   int            n_cmp = 0;
   int            n_bad = 0;

   mem_responder #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .WAIT(WAIT_T)) dut (
      .clk(clk), .rst(rst), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
      .rdata(rdata), .rdata_vld(rdata_vld), .ack(ack), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, ".busy"}, busy, 0);
      chk({tag, ".vld"}, rdata_vld, 0);
      chk({tag, ".ack"}, ack, 0);
      chk({tag, ".err"}, err, 0);
   endtask

   // One access: strobe raised now, held for h edges, then dropped. Edge 1 is capture;
   // the response lands on edge 2+WAIT; HOLD exits on the first edge seeing the strobe low.
   task automatic do_access(input logic is_wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input int h);
      int   resp_c, last_c;
      logic in_rng;
      in_rng = (int'(a) < DEPTH);
      resp_c = 2 + WAIT_T;
      last_c = (h > resp_c) ? h : resp_c;
      addr   = a;
      wdata  = d;
      if (is_wr) wr = 1'b1; else rd = 1'b1;
      for (int c = 1; c <= last_c + 1; c++) begin
         tick(1);
         if (c == 1) begin
            addr  = AW'($urandom);
            wdata = DW'($urandom);
         end
         if (c == resp_c) begin
            if (!in_rng)    exp_rdata = '0;
            else if (is_wr) ref_mem[int'(a)] = d;
            else            exp_rdata = ref_mem[int'(a)];
         end
         chk("busy", busy, (c <= last_c));
         chk("ack", ack, (is_wr && in_rng && c == resp_c));
         chk("err", err, (!in_rng && c == resp_c));
         chk("rdata_vld", rdata_vld, (!is_wr && in_rng && c >= resp_c && c <= h));
         chk("rdata", rdata, exp_rdata);
         if (c == h) begin
            rd = 1'b0;
            wr = 1'b0;
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation ran past its time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [AW-1:0] ra;
      logic [AW-1:0] trunc;
      logic [16:0]   wide;
      int            sel;

      rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
      exp_rdata = '0;
      tick(2);
      chk("reset.rdata", rdata, 0);
      chk_quiet("reset");
      rst = 1'b0;
      tick(1);

      for (int i = 0; i < DEPTH; i++) do_access(1'b1, AW'(i), DW'($urandom), 3);

      // Write then read back 0x005.
      do_access(1'b1, 13'h005, 8'hA5, 3);
      do_access(1'b0, 13'h005, 8'h00, 3);
      chk("wr_rd.rdata", rdata, 8'hA5);

      // Long strobe: exactly one response.
      do_access(1'b0, 13'h005, 8'h00, 6);

      // Simultaneous rises in IDLE.
      rd = 1'b1; wr = 1'b1; addr = 13'h005; wdata = 8'h11;
      tick(1);
      chk("both.err", err, 1);
      chk("both.busy", busy, 0);
      tick(1);
      chk("both.err_clr", err, 0);
      chk("both.busy2", busy, 0);
      rd = 1'b0; wr = 1'b0;
      tick(1);
      do_access(1'b0, 13'h005, 8'h00, 3);
      chk("both.ram", rdata, 8'hA5);

      // Out-of-range write after address truncation; boundary addresses too.
      wide  = 17'h1FF00;
      trunc = wide[AW-1:0];
      do_access(1'b1, trunc, 8'h5A, 3);
      do_access(1'b0, 13'h000, 8'h00, 3);
      do_access(1'b1, AW'(DEPTH), 8'h66, 3);
      do_access(1'b0, AW'(DEPTH), 8'h00, 4);
      do_access(1'b1, AW'(DEPTH - 1), 8'hC3, 3);
      do_access(1'b0, AW'(DEPTH - 1), 8'h00, 3);

      // Write rising during a read's wait state.
      rd = 1'b1; addr = 13'h005;
      tick(1);
      wr = 1'b1; addr = 13'h006; wdata = ~ref_mem[6];
      tick(1);
      chk("collide.err", err, 1);
      chk("collide.busy", busy, 1);
      chk("collide.ack", ack, 0);
      tick(1);
      exp_rdata = ref_mem[5];
      chk("collide.err_clr", err, 0);
      chk("collide.vld", rdata_vld, 1);
      chk("collide.rdata", rdata, exp_rdata);
      chk("collide.ack2", ack, 0);
      rd = 1'b0; wr = 1'b0;
      tick(1);
      chk_quiet("collide.end");
      do_access(1'b0, 13'h006, 8'h00, 3);

      // Reset in the middle of a write's wait state.
      do_access(1'b1, 13'h010, 8'h77, 3);
      do_access(1'b0, 13'h005, 8'h00, 3);
      wr = 1'b1; addr = 13'h010; wdata = 8'h3C;
      tick(1);
      chk("rstmid.busy", busy, 1);
      rst = 1'b1;
      #1;
      exp_rdata = '0;
      chk("rstmid.rdata", rdata, 0);
      chk_quiet("rstmid");
      wr = 1'b0;
      tick(1);
      rst = 1'b0;
      tick(1);
      do_access(1'b0, 13'h010, 8'h00, 3);
      chk("rstmid.ram", rdata, 8'h77);

      // Randomized traffic, including strobes dropped before the response.
      for (int t = 0; t < 200; t++) begin
         sel = int'($urandom_range(0, 9));
         if (sel == 0)      ra = AW'($urandom_range(DEPTH, (1 << AW) - 1));
         else if (sel == 1) ra = AW'(DEPTH - 1);
         else               ra = AW'($urandom_range(0, DEPTH - 1));
         do_access(1'($urandom), ra, DW'($urandom), int'($urandom_range(1, 6)));
         tick(int'($urandom_range(0, 2)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
